// File: rtl/stopwatch_pkg.sv
// stopwatch_pkg: shared state encoding and prescaler sizing for the stopwatch control path
package stopwatch_pkg;
    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_RUN = 2'd1;
    localparam logic [1:0] ST_LAP = 2'd2;
    localparam logic [1:0] ST_STOP = 2'd3;
    localparam int TICK_DIV_DEF = 500000;
    localparam int PW = 20;
endpackage

// File: rtl/stopwatch_ctrl_btn_rise.sv
// btn_rise: turns a debounced button level into a one-cycle rising-edge strobe
module btn_rise (
    input  logic clk,
    input  logic rst,
    input  logic level,
    output logic rise
);
    logic prev;
    // history starts high so a button held through reset must be released before it counts
    always_ff @(posedge clk or posedge rst)
        if (rst) prev <= 1'b1;
        else prev <= level;
    assign rise = level & ~prev;
endmodule

// File: rtl/stopwatch_ctrl.sv
// stopwatch_ctrl: run/lap/stop FSM driving the time counter's tick, clear and display hold
module stopwatch_ctrl
    import stopwatch_pkg::*;
#(
    parameter int TICK_DIV = TICK_DIV_DEF
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       btn_ss,
    input  logic       btn_lc,
    output logic       tick_en,
    output logic       cnt_clr,
    output logic       disp_hold,
    output logic       running,
    output logic [1:0] state
);
    localparam logic [PW-1:0] LAST = PW'(TICK_DIV - 1);
    logic ss_rise, lc_rise, wrap;
    logic [1:0] nxt;
    logic [PW-1:0] presc;
    btn_rise u_ss (.clk(clk), .rst(rst), .level(btn_ss), .rise(ss_rise));
    btn_rise u_lc (.clk(clk), .rst(rst), .level(btn_lc), .rise(lc_rise));
    assign running = (state == ST_RUN) || (state == ST_LAP);
    assign disp_hold = state == ST_LAP;
    assign wrap = presc == LAST;
    // next state; start/stop wins when both buttons rise together
    always_comb begin
        nxt = state;
        case (state)
            ST_IDLE: nxt = ss_rise ? ST_RUN : ST_IDLE;
            ST_RUN:  nxt = ss_rise ? ST_STOP : lc_rise ? ST_LAP : ST_RUN;
            ST_LAP:  nxt = ss_rise ? ST_STOP : lc_rise ? ST_RUN : ST_LAP;
            ST_STOP: nxt = ss_rise ? ST_RUN : lc_rise ? ST_IDLE : ST_STOP;
            default: nxt = ST_IDLE;
        endcase
    end
    // state, prescaler (held in STOP to keep sub-tick phase) and registered strobes
    always_ff @(posedge clk or posedge rst)
        if (rst) begin
            state <= ST_IDLE;
            presc <= '0;
            tick_en <= 1'b0;
            cnt_clr <= 1'b0;
        end else begin
            state <= nxt;
            cnt_clr <= (state == ST_STOP) && (nxt == ST_IDLE);
            presc <= (state == ST_IDLE) ? '0 : !running ? presc : wrap ? '0 : presc + PW'(1);
            tick_en <= running && wrap && (nxt != ST_STOP);
        end
endmodule
